// File: rtl/counter_bank_pkg.sv
// Shared definitions for the lock-gated counter bank.
// Contents:
//   fsm_state_t    - lock qualification states (WAIT_LOCK, SETTLE, RUN)
//   load_ch_width  - width of the load channel select, never below 1 bit
package counter_bank_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } fsm_state_t;

  function automatic int load_ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One WIDTH-bit counter of the bank with synchronous load, up/down stepping
// and wrap or saturate behaviour at the range limits.
// Ports:
//   clk_inner   in   counting clock
//   reset       in   asynchronous, active-high (already release-synchronised)
//   load        in   load this channel this cycle (wins over a step)
//   load_value  in   value written on load
//   step_en     in   take one step this cycle
//   dir_up      in   1 = step up, 0 = step down
//   saturate    in   1 = hold at the limit, 0 = wrap around
//   count       out  current counter value
//   tc          out  one-cycle terminal-count pulse, aligned with the count update
module counter_channel #(
  parameter int WIDTH = 8
) (
  input  logic             clk_inner,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step_en,
  input  logic             dir_up,
  input  logic             saturate,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_d;
  logic             tc_d;

  // A wrap step pulses tc as it crosses the boundary; a saturating step pulses
  // tc only on the step that arrives at the limit, never while parked there.
  always_comb begin
    count_d = count;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (step_en) begin
      if (dir_up) begin
        if (count == MAX_VAL) begin
          if (!saturate) begin
            count_d = '0;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count + ONE;
          tc_d    = saturate && (count == (MAX_VAL - ONE));
        end
      end else begin
        if (count == '0) begin
          if (!saturate) begin
            count_d = MAX_VAL;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count - ONE;
          tc_d    = saturate && (count == ONE);
        end
      end
    end
  end

  always_ff @(posedge clk_inner or posedge reset) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_d;
      tc    <= tc_d;
    end
  end

endmodule

// File: rtl/lock_gated_counter_bank.sv
// Bank of CHANNELS independent counters clocked by the clock-wizard output.
// Counting only happens once the wizard lock has been synchronised and has
// stayed high for SETTLE_CYCLES cycles; a shared prescaler paces the steps.
// Ports:
//   clk_inner   in   counting clock (clock-wizard clk_out1)
//   reset       in   asynchronous, active-high
//   locked      in   clock-wizard lock, asynchronous to clk_inner
//   enable      in   per-channel count enable
//   dir_up      in   per-channel direction, 1 = up
//   saturate    in   per-channel mode, 1 = saturate, 0 = wrap
//   prescale    in   step every prescale+1 RUN cycles
//   load        in   synchronous load strobe
//   load_ch     in   channel to load (out-of-range values are ignored)
//   load_value  in   value to load
//   count       out  channel i at bits [i*WIDTH +: WIDTH]
//   tc          out  per-channel terminal-count pulse
//   running     out  high while the bank is in RUN
module lock_gated_counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int CHANNELS      = 4,
  parameter int PRESCALE_W    = 8,
  parameter int SETTLE_CYCLES = 16,
  localparam int LOAD_CH_W    = load_ch_width(CHANNELS)
) (
  input  logic                      clk_inner,
  input  logic                      reset,
  input  logic                      locked,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       dir_up,
  input  logic [CHANNELS-1:0]       saturate,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic                      load,
  input  logic [LOAD_CH_W-1:0]      load_ch,
  input  logic [WIDTH-1:0]          load_value,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc,
  output logic                      running
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [1:0]            rst_pipe;
  logic                  rst_int;
  logic [1:0]            lock_pipe;
  logic                  lock_s;
  fsm_state_t            state_q;
  fsm_state_t            state_d;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [SETTLE_W-1:0]   settle_d;
  logic [PRESCALE_W-1:0] prescaler;
  logic                  run_active;
  logic                  tick;

  // Reset asserts immediately but is released only on a clock edge, so no
  // flop in the bank sees a reset removal close to clk_inner.
  always_ff @(posedge clk_inner or posedge reset) begin
    if (reset) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end

  assign rst_int = rst_pipe[1];

  // Two-flop synchroniser for the wizard lock, which comes from another domain.
  always_ff @(posedge clk_inner or posedge rst_int) begin
    if (rst_int) begin
      lock_pipe <= 2'b00;
    end else begin
      lock_pipe <= {lock_pipe[0], locked};
    end
  end

  assign lock_s = lock_pipe[1];

  always_ff @(posedge clk_inner or posedge rst_int) begin
    if (rst_int) begin
      state_q    <= WAIT_LOCK;
      settle_cnt <= '0;
      running    <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_cnt <= settle_d;
      running    <= (state_d == RUN);
    end
  end

  // Any low sample of the synchronised lock restarts qualification, so RUN
  // is only reached after an unbroken run of SETTLE_CYCLES high samples.
  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_d = RUN;
        end else begin
          settle_d = settle_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
  end

  assign run_active = (state_q == RUN);
  assign tick       = run_active && (prescaler == prescale);

  // A divisor lowered below the running count is not special-cased: the
  // prescaler rolls through its full range before matching again.
  always_ff @(posedge clk_inner or posedge rst_int) begin
    if (rst_int) begin
      prescaler <= '0;
    end else if (!run_active || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    counter_channel #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk_inner  (clk_inner),
      .reset      (rst_int),
      .load       (load && (32'(load_ch) == i)),
      .load_value (load_value),
      .step_en    (tick && enable[i]),
      .dir_up     (dir_up[i]),
      .saturate   (saturate[i]),
      .count      (count[i*WIDTH +: WIDTH]),
      .tc         (tc[i])
    );
  end

endmodule

// File: tb/tb_lock_gated_counter_bank.sv
// Randomised scoreboard bench for lock_gated_counter_bank. A reference model
// predicts the outputs after every clock edge; a monitor compares them.
module tb_lock_gated_counter_bank;

  localparam int W   = 8;
  localparam int CH  = 5;
  localparam int PW  = 8;
  localparam int SC  = 16;
  localparam int LCW = 3;

  typedef struct packed {
    logic [CH*W-1:0] count;
    logic [CH-1:0]   tc;
    logic            running;
  } exp_t;

  logic            clk_inner = 1'b0;
  logic            reset;
  logic            locked;
  logic [CH-1:0]   enable;
  logic [CH-1:0]   dir_up;
  logic [CH-1:0]   saturate;
  logic [PW-1:0]   prescale;
  logic            load;
  logic [LCW-1:0]  load_ch;
  logic [W-1:0]    load_value;
  logic [CH*W-1:0] count;
  logic [CH-1:0]   tc;
  logic            running;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  lock_gated_counter_bank #(
    .WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW), .SETTLE_CYCLES(SC)
  ) dut (
    .clk_inner  (clk_inner),
    .reset      (reset),
    .locked     (locked),
    .enable     (enable),
    .dir_up     (dir_up),
    .saturate   (saturate),
    .prescale   (prescale),
    .load       (load),
    .load_ch    (load_ch),
    .load_value (load_value),
    .count      (count),
    .tc         (tc),
    .running    (running)
  );

  always #5 clk_inner = ~clk_inner;

  // Reference model: lock must be seen high (two cycles late) for SC+1
  // consecutive edges before counting; counters follow plain +/-1 arithmetic.
  int  m_cnt[CH];
  bit  m_tc[CH];
  bit  m_running;
  int  streak;
  bit  lk1, lk2;
  int  psc;

  initial begin : model
    bit   ls, run_now, tk;
    int   maxv;
    exp_t e;
    maxv = (1 << W) - 1;
    forever begin
      @(posedge clk_inner);
      if (reset) begin
        for (int i = 0; i < CH; i++) begin
          m_cnt[i] = 0;
          m_tc[i]  = 0;
        end
        m_running = 0; streak = 0; lk1 = 0; lk2 = 0; psc = 0;
      end else begin
        ls  = lk2;
        lk2 = lk1;
        lk1 = locked;
        run_now = (streak >= SC + 1);
        streak  = ls ? ((streak < 1000) ? streak + 1 : streak) : 0;
        tk = 0;
        if (run_now) begin
          tk  = (psc == int'(prescale));
          psc = tk ? 0 : (psc + 1) % (1 << PW);
        end else begin
          psc = 0;
        end
        for (int i = 0; i < CH; i++) begin
          m_tc[i] = 0;
          if (load && int'(load_ch) == i) begin
            m_cnt[i] = int'(load_value);
          end else if (run_now && tk && enable[i]) begin
            if (dir_up[i]) begin
              if (m_cnt[i] == maxv) begin
                if (!saturate[i]) begin m_cnt[i] = 0; m_tc[i] = 1; end
              end else begin
                m_cnt[i] = m_cnt[i] + 1;
                m_tc[i]  = saturate[i] && (m_cnt[i] == maxv);
              end
            end else begin
              if (m_cnt[i] == 0) begin
                if (!saturate[i]) begin m_cnt[i] = maxv; m_tc[i] = 1; end
              end else begin
                m_cnt[i] = m_cnt[i] - 1;
                m_tc[i]  = saturate[i] && (m_cnt[i] == 0);
              end
            end
          end
        end
        m_running = (streak >= SC + 1);
      end
      for (int i = 0; i < CH; i++) begin
        e.count[i*W +: W] = W'(m_cnt[i]);
        e.tc[i]           = m_tc[i];
      end
      e.running = m_running;
      exp_q.push_back(e);
    end
  end

  task automatic check_value(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty got=0 expected=1 entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check_value("count", 64'(count), 64'(e.count));
      check_value("tc", 64'(tc), 64'(e.tc));
      check_value("running", 64'(running), 64'(e.running));
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk_inner);
      #1;
      check_output();
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk_inner);
  endtask

  // One-cycle load strobe followed by n-1 idle cycles.
  task automatic apply_stimulus(input int ch, input int val, input int n);
    load       = 1'b1;
    load_ch    = LCW'(ch);
    load_value = W'(val);
    run_cycles(1);
    load = 1'b0;
    if (n > 1) run_cycles(n - 1);
  endtask

  initial begin : stimulus
    reset = 1'b1; locked = 1'b0; enable = '0; dir_up = '0; saturate = '0;
    prescale = '0; load = 1'b0; load_ch = '0; load_value = '0;
    run_cycles(3);
    reset = 1'b0;
    run_cycles(4);

    $display("[TB] lock qualification");
    locked = 1'b1;
    run_cycles(24);

    $display("[TB] wrap up on channel 0");
    dir_up[0] = 1'b1; saturate[0] = 1'b0;
    apply_stimulus(0, 8'hFE, 1);
    enable[0] = 1'b1;
    run_cycles(4);
    enable = '0;

    $display("[TB] saturate down with prescale on channel 1");
    dir_up[1] = 1'b0; saturate[1] = 1'b1; prescale = 8'd3;
    apply_stimulus(1, 8'h02, 1);
    enable[1] = 1'b1;
    run_cycles(16);
    enable = '0; prescale = '0;

    $display("[TB] lock drop on channel 2");
    dir_up[2] = 1'b1; saturate[2] = 1'b0;
    apply_stimulus(2, 8'h0F, 1);
    enable[2] = 1'b1;
    run_cycles(1);
    enable[2] = 1'b0;
    locked = 1'b0;
    run_cycles(5);
    enable[2] = 1'b1;
    locked = 1'b1;
    run_cycles(25);

    $display("[TB] load priority and out-of-range load");
    enable = '1; dir_up = '1; saturate = '0; prescale = '0;
    apply_stimulus(3, 8'h55, 1);
    apply_stimulus(5, 8'hA5, 1);
    apply_stimulus(6, 8'h3C, 1);
    apply_stimulus(7, 8'hC3, 2);

    $display("[TB] randomised traffic");
    for (int c = 0; c < 3000; c++) begin
      enable   = CH'($urandom);
      dir_up   = CH'($urandom);
      saturate = CH'($urandom);
      if ($urandom_range(0, 200) == 0) prescale = PW'($urandom);
      else if ($urandom_range(0, 20) == 0) prescale = PW'($urandom_range(0, 3));
      load    = ($urandom_range(0, 7) == 0);
      load_ch = LCW'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: load_value = 8'h00;
        1: load_value = 8'h01;
        2: load_value = 8'hFE;
        3: load_value = 8'hFF;
        default: load_value = W'($urandom);
      endcase
      if (locked && $urandom_range(0, 150) == 0) locked = 1'b0;
      else if (!locked && $urandom_range(0, 7) == 0) locked = 1'b1;
      run_cycles(1);
    end
    load = 1'b0;

    $display("[TB] asynchronous reset mid-run");
    locked = 1'b1; enable = '1; dir_up = '1; saturate = '0; prescale = '0;
    run_cycles(40);
    @(posedge clk_inner);
    #3;
    reset  = 1'b1;
    locked = 1'b0;
    #1;
    check_value("reset_count", 64'(count), 64'd0);
    check_value("reset_tc", 64'(tc), 64'd0);
    check_value("reset_running", 64'(running), 64'd0);
    @(negedge clk_inner);
    run_cycles(2);
    reset = 1'b0;
    run_cycles(4);
    locked = 1'b1;
    run_cycles(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
